// File: rtl/vram_pkg.sv
// vram_pkg
//   Shared definitions for the screen-RAM arbiter: default geometry, the CPU
//   handshake FSM encoding and the owner tags that route RAM read returns.
package vram_pkg;

    localparam int VRAM_ADDR_W  = 13;   // 32 words/line x 256 lines
    localparam int VRAM_DATA_W  = 16;
    localparam int VRAM_VGA_LAT = 3;    // minimum achievable scanout latency

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RD_WAIT,
        ST_DONE
    } cpu_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_CPU
    } owner_t;

endpackage

// File: rtl/vram_ret_pipe.sv
// vram_ret_pipe
//   Return path of the screen RAM. Carries the owner tag of each access from
//   the memory-issue stage to the data-return stage and steers the read data
//   to the right requester. VGA returns pass through VGA_LAT-3 extra delay
//   stages before landing in vga_rdata.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   own_p1      : owner tag registered alongside mem_re/mem_we
//   mem_rdata   : RAM read data (valid one cycle after mem_re)
//   cpu_hit     : current mem_rdata belongs to a CPU read
//   vga_rdata   : VGA read data, held until the next VGA return
import vram_pkg::*;

module vram_ret_pipe #(
    parameter int DATA_W  = VRAM_DATA_W,
    parameter int VGA_LAT = VRAM_VGA_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  owner_t            own_p1,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_hit,
    output logic [DATA_W-1:0] vga_rdata
);

    owner_t            own_p2;
    logic              vld_p2;
    logic              ret_vld;
    logic [DATA_W-1:0] ret_data;

    // ---- stage p2: tag aligned with mem_rdata ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_p2 <= OWN_NONE;
        end else begin
            own_p2 <= own_p1;
        end
    end

    assign cpu_hit = (own_p2 == OWN_CPU);
    assign vld_p2  = (own_p2 == OWN_VGA);

    if (VGA_LAT < 3) begin : g_lat_check
        $error("vram_ret_pipe: VGA_LAT must be >= 3");
    end

    if (VGA_LAT > 3) begin : g_dly
        localparam int DLY = VGA_LAT - 3;

        logic [DLY-1:0]    vld_dly;
        logic [DATA_W-1:0] dat_dly [DLY];

        // ---- stages p3..: extra scanout delay ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_dly <= '0;
            end else begin
                vld_dly[0] <= vld_p2;
                for (int i = 1; i < DLY; i++) begin
                    vld_dly[i] <= vld_dly[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            dat_dly[0] <= mem_rdata;
            for (int i = 1; i < DLY; i++) begin
                dat_dly[i] <= dat_dly[i-1];
            end
        end

        assign ret_vld  = vld_dly[DLY-1];
        assign ret_data = dat_dly[DLY-1];
    end else begin : g_nodly
        assign ret_vld  = vld_p2;
        assign ret_data = mem_rdata;
    end

    // ---- output: VGA data register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_rdata <= '0;
        end else if (ret_vld) begin
            vga_rdata <= ret_data;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares a single-port registered-output screen RAM between the VGA
//   scanout (fixed latency, never stalled) and the CPU (req/ack, stalled only
//   when it collides with a VGA read).
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   vga_rden, vga_raddr, vga_rdata   : VGA read strobe/address, read data
//   cpu_req, cpu_we, cpu_addr,
//   cpu_wdata, cpu_ack, cpu_rdata    : CPU handshake port
//   mem_addr, mem_wdata, mem_we,
//   mem_re, mem_rdata                : RAM macro interface (outputs registered)
//   conflict                         : pulse the cycle after a CPU deferral
import vram_pkg::*;

module vram_arbiter #(
    parameter int ADDR_W  = VRAM_ADDR_W,
    parameter int DATA_W  = VRAM_DATA_W,
    parameter int VGA_LAT = VRAM_VGA_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_rden,
    input  logic [ADDR_W-1:0] vga_raddr,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              conflict
);

    cpu_state_t state_q, state_d;
    logic       cpu_issue;
    logic       cpu_defer;
    owner_t     own_p1;
    logic       cpu_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The CPU only reaches the RAM from IDLE, and only on a cycle with no
    // VGA strobe; every later state is already past the memory port, so a
    // VGA read arriving then needs no arbitration.
    always_comb begin
        state_d   = state_q;
        cpu_issue = 1'b0;
        cpu_defer = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    if (vga_rden) begin
                        cpu_defer = 1'b1;
                    end else begin
                        cpu_issue = 1'b1;
                        state_d   = cpu_we ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_WRITE:   state_d = ST_DONE;
            ST_READ:    state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ---- stage p1: memory issue (mem_* registers act as the CPU latch) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            own_p1    <= OWN_NONE;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            own_p1 <= OWN_NONE;
            if (vga_rden) begin
                mem_re   <= 1'b1;
                mem_addr <= vga_raddr;
                own_p1   <= OWN_VGA;
            end else if (cpu_issue) begin
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                mem_we    <= cpu_we;
                mem_re    <= !cpu_we;
                own_p1    <= cpu_we ? OWN_NONE : OWN_CPU;
            end
        end
    end

    // A write completes as soon as it is on the port; a read acks when its
    // data is captured, one cycle after RD_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            conflict  <= 1'b0;
        end else begin
            cpu_ack  <= (cpu_issue && cpu_we) || (state_q == ST_RD_WAIT);
            conflict <= cpu_defer;
            if (cpu_hit) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

    vram_ret_pipe #(
        .DATA_W  (DATA_W),
        .VGA_LAT (VGA_LAT)
    ) u_ret_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .own_p1    (own_p1),
        .mem_rdata (mem_rdata),
        .cpu_hit   (cpu_hit),
        .vga_rdata (vga_rdata)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Directed stimulus with a scoreboard: stimulus tasks push the expected
//   CPU completion (data, latency) and VGA return data into queues; a monitor
//   pops and compares them whenever the DUT acks or a VGA return is due.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vga_rden = 1'b0;
    logic [AW-1:0] vga_raddr = '0;
    logic [DW-1:0] vga_rdata;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata = '0;
    logic          conflict;

    vram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vga_rden  (vga_rden),
        .vga_raddr (vga_raddr),
        .vga_rdata (vga_rdata),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .conflict  (conflict)
    );

    always #5 clk = ~clk;

    // Screen RAM model: registered output, one-cycle read latency.
    logic [DW-1:0] ram [0:8191];
    bit            ram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 8192; i++) ram[i] = '0;
            ram[13'h0000] = 16'hA5A5;
            ram[13'h0001] = 16'h1234;
            ram[13'h0002] = 16'hCAFE;
            ram[13'h0003] = 16'h5A5A;
            ram[13'h0010] = 16'hDEAD;
            ram[13'h0020] = 16'h1111;
            ram[13'h0021] = 16'h2222;
            ram[13'h0100] = 16'h00FF;
            ram_loaded = 1'b1;
        end
        if (mem_re) mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    typedef struct {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] data;
        int            lat;
        int            start;
    } cpu_exp_t;

    cpu_exp_t      cpu_q[$];
    logic [DW-1:0] vga_q[$];
    int            n_tests = 0;
    int            n_fail = 0;
    int            cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: sample inputs at the edge, check outputs 1 time unit later.
    logic [2:0]    hist = '0;
    logic [DW-1:0] vga_last = '0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                hist     = '0;
                vga_last = '0;
            end else begin
                hist = {hist[1:0], vga_rden};
            end
            #1;
            if (rst_n) begin
                if (mem_we && mem_re) chk("mem_exclusive", {mem_we, mem_re}, 2'b00);
                if (hist[2]) begin
                    if (vga_q.size() == 0) begin
                        chk("vga_unexpected_return", 1, 0);
                    end else begin
                        logic [DW-1:0] e;
                        e = vga_q.pop_front();
                        chk("vga_rdata", vga_rdata, e);
                        vga_last = e;
                    end
                end else begin
                    chk("vga_rdata_hold", vga_rdata, vga_last);
                end
                if (cpu_ack) begin
                    if (cpu_q.size() == 0) begin
                        chk("cpu_ack_unexpected", cpu_ack, 0);
                    end else begin
                        cpu_exp_t e;
                        e = cpu_q.pop_front();
                        chk("cpu_ack_latency", cyc - e.start + 1, e.lat);
                        if (e.rd) begin
                            chk("cpu_rdata", cpu_rdata, e.data);
                        end else begin
                            chk("wr_mem_we", mem_we, 1);
                            chk("wr_mem_addr", mem_addr, e.addr);
                            chk("wr_mem_wdata", mem_wdata, e.wdata);
                        end
                    end
                end
            end
        end
    end

    task automatic vga_rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        @(negedge clk);
        vga_rden  = 1'b1;
        vga_raddr = a;
        vga_q.push_back(exp);
        @(posedge clk);
        #1;
        chk("vga_mem_re", mem_re, 1);
        chk("vga_mem_addr", mem_addr, a);
        @(negedge clk);
        vga_rden = 1'b0;
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp, input int lat);
        cpu_exp_t e;
        bit       got;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        e.rd      = !we;
        e.addr    = a;
        e.wdata   = wd;
        e.data    = exp;
        e.lat     = lat;
        e.start   = cyc + 1;
        cpu_q.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (cpu_ack) got = 1'b1;
        end
        if (!got) begin
            chk("cpu_ack_timeout", 0, 1);
            void'(cpu_q.pop_back());
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_mem_addr"}, mem_addr, 0);
        chk({nm, "_mem_wdata"}, mem_wdata, 0);
        chk({nm, "_mem_ctl"}, {mem_we, mem_re}, 0);
        chk({nm, "_cpu_ack"}, cpu_ack, 0);
        chk({nm, "_cpu_rdata"}, cpu_rdata, 0);
        chk({nm, "_vga_rdata"}, vga_rdata, 0);
        chk({nm, "_conflict"}, conflict, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // VGA only, with a hold interval between the two returns
        vga_rd(13'h0000, 16'hA5A5);
        repeat (14) @(negedge clk);
        vga_rd(13'h0001, 16'h1234);
        repeat (5) @(negedge clk);

        // CPU write to the top word, read it back, plain read
        cpu_op(1'b1, 13'h1FFF, 16'hBEEF, 16'h0000, 1);
        cpu_op(1'b0, 13'h1FFF, 16'h0000, 16'hBEEF, 3);
        cpu_op(1'b0, 13'h0100, 16'h0000, 16'h00FF, 3);

        // Collision: VGA wins, CPU read retried next cycle
        fork
            cpu_op(1'b0, 13'h0002, 16'h0000, 16'hCAFE, 4);
            vga_rd(13'h0003, 16'h5A5A);
            begin
                @(negedge clk);
                @(posedge clk);
                #1;
                chk("conflict_pulse", conflict, 1);
                @(posedge clk);
                #1;
                chk("conflict_clear", conflict, 0);
            end
        join
        repeat (3) @(negedge clk);

        // Interleave: VGA read one cycle behind a CPU read, no data swap
        fork
            cpu_op(1'b0, 13'h0020, 16'h0000, 16'h1111, 3);
            begin
                @(negedge clk);
                vga_rd(13'h0021, 16'h2222);
            end
        join
        repeat (3) @(negedge clk);

        // Back-to-back VGA strobes hold off a CPU write by two cycles
        fork
            cpu_op(1'b1, 13'h0040, 16'h7777, 16'h0000, 3);
            begin
                @(negedge clk);
                vga_rden  = 1'b1;
                vga_raddr = 13'h0000;
                vga_q.push_back(16'hA5A5);
                @(negedge clk);
                vga_raddr = 13'h0001;
                vga_q.push_back(16'h1234);
                @(negedge clk);
                vga_rden = 1'b0;
            end
        join
        cpu_op(1'b0, 13'h0040, 16'h0000, 16'h7777, 3);
        repeat (4) @(negedge clk);

        // Reset while a CPU read sits in RD_WAIT: dropped with no ack
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0010;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk_all_zero("reset_mid_read");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_ack_after_reset", cpu_ack, 0);
        end
        cpu_op(1'b1, 13'h0011, 16'h4242, 16'h0000, 1);
        cpu_op(1'b0, 13'h0010, 16'h0000, 16'hDEAD, 3);
        cpu_op(1'b0, 13'h0011, 16'h0000, 16'h4242, 3);

        repeat (5) @(negedge clk);
        chk("cpu_queue_drained", cpu_q.size(), 0);
        chk("vga_queue_drained", vga_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
